// File: rtl/rfg_regbank_pkg.sv
// rtl/rfg_regbank_pkg.sv - register map and FLAGS bit indices for rfg_regbank
package rfg_regbank_pkg;
   localparam logic [15:0] ADDR_ID         = 16'h0000;
   localparam logic [15:0] ADDR_CTRL       = 16'h0001;
   localparam logic [15:0] ADDR_DIV_LO     = 16'h0002;
   localparam logic [15:0] ADDR_DIV_HI     = 16'h0003;
   localparam logic [15:0] ADDR_STATUS     = 16'h0004;
   localparam logic [15:0] ADDR_FIFO_COUNT = 16'h0005;
   localparam logic [15:0] ADDR_FIFO_DATA  = 16'h0006;
   localparam logic [15:0] ADDR_FLAGS      = 16'h0007;
   localparam logic [15:0] ADDR_WR_COUNT   = 16'h0008;

   localparam int FLAG_UNDERFLOW = 0;
   localparam int FLAG_BURST     = 1;
endpackage

// File: rtl/rfg_regbank_fifo.sv
// rtl/rfg_regbank_fifo.sv - byte FIFO feeding the FIFO_DATA readout register
module rfg_regbank_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [7:0]               i_push_data,
   input  logic                     i_pop,
   output logic [7:0]               o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end
endmodule

// File: rtl/rfg_regbank.sv
// rtl/rfg_regbank.sv - byte-wide register bank with divider shadow, W1C flags and readout FIFO
module rfg_regbank
   import rfg_regbank_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] ID_VALUE   = 8'hD5
) (
   input  logic        clk,
   input  logic        res,
   input  logic [15:0] rfg_address,
   input  logic        rfg_read,
   output logic        rfg_read_valid,
   output logic [7:0]  rfg_read_value,
   input  logic        rfg_write,
   input  logic        rfg_write_last,
   input  logic [7:0]  rfg_write_value,
   output logic [7:0]  cfg_ctrl,
   output logic [15:0] cfg_divider,
   input  logic [7:0]  status_in,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]       r_ctrl;
   logic [7:0]       r_div_lo;
   logic [7:0]       r_div_hi;
   logic [15:0]      r_divider;
   logic [7:0]       r_wr_count;
   logic [1:0]       r_flags;
   logic             r_rdy;
   logic             r_read_valid;
   logic [7:0]       r_read_value;

   logic [7:0]       w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_rd_fifo;
   logic             w_pop;
   logic             w_push;
   logic [1:0]       w_flag_set;
   logic [7:0]       w_rdata;

   assign w_rd_fifo     = rfg_read && (rfg_address == ADDR_FIFO_DATA);
   assign w_pop         = w_rd_fifo && !w_empty;
   assign s_axis_tready = r_rdy && !w_full;
   assign w_push        = s_axis_tvalid && s_axis_tready;

   always_comb begin
      w_flag_set                 = 2'b00;
      w_flag_set[FLAG_UNDERFLOW] = w_rd_fifo && w_empty;
      w_flag_set[FLAG_BURST]     = rfg_write && rfg_write_last;
   end

   // Read data comes from current state, so a same-edge write is not visible.
   always_comb begin
      w_rdata = 8'h00;
      case (rfg_address)
         ADDR_ID:         w_rdata = ID_VALUE;
         ADDR_CTRL:       w_rdata = r_ctrl;
         ADDR_DIV_LO:     w_rdata = r_div_lo;
         ADDR_DIV_HI:     w_rdata = r_div_hi;
         ADDR_STATUS:     w_rdata = status_in;
         ADDR_FIFO_COUNT: w_rdata = {{(8-CNT_W){1'b0}}, w_count};
         ADDR_FIFO_DATA:  w_rdata = w_empty ? 8'h00 : w_head;
         ADDR_FLAGS:      w_rdata = {6'b0, r_flags};
         ADDR_WR_COUNT:   w_rdata = r_wr_count;
         default:         w_rdata = 8'h00;
      endcase
   end

   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         r_ctrl       <= '0;
         r_div_lo     <= '0;
         r_div_hi     <= '0;
         r_divider    <= '0;
         r_wr_count   <= '0;
         r_flags      <= '0;
         r_rdy        <= 1'b0;
         r_read_valid <= 1'b0;
         r_read_value <= '0;
      end else begin
         r_rdy        <= 1'b1;
         r_read_valid <= rfg_read;
         if (rfg_read) r_read_value <= w_rdata;
         if (rfg_write) begin
            r_wr_count <= r_wr_count + 8'd1;
            case (rfg_address)
               ADDR_CTRL:   r_ctrl   <= rfg_write_value;
               ADDR_DIV_LO: r_div_lo <= rfg_write_value;
               ADDR_DIV_HI: begin
                  r_div_hi  <= rfg_write_value;
                  r_divider <= {rfg_write_value, r_div_lo};
               end
               default: ;
            endcase
         end
         // Set events win over a same-edge write-1-to-clear.
         if (rfg_write && rfg_address == ADDR_FLAGS)
            r_flags <= (r_flags & ~rfg_write_value[1:0]) | w_flag_set;
         else
            r_flags <= r_flags | w_flag_set;
      end
   end

   assign rfg_read_valid = r_read_valid;
   assign rfg_read_value = r_read_value;
   assign cfg_ctrl       = r_ctrl;
   assign cfg_divider    = r_divider;

   rfg_regbank_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (res),
      .i_push      (w_push),
      .i_push_data (s_axis_tdata),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );
endmodule

// File: tb/tb_rfg_regbank.sv
// tb/tb_rfg_regbank.sv - scoreboard bench for rfg_regbank against a queue-based register model
module tb_rfg_regbank;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic [15:0] rfg_address = '0;
   logic        rfg_read = 1'b0;
   logic        rfg_read_valid;
   logic [7:0]  rfg_read_value;
   logic        rfg_write = 1'b0;
   logic        rfg_write_last = 1'b0;
   logic [7:0]  rfg_write_value = '0;
   logic [7:0]  cfg_ctrl;
   logic [15:0] cfg_divider;
   logic [7:0]  status_in = '0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;

   int checks = 0;
   int errors = 0;

   logic [7:0]  m_ctrl, m_div_lo, m_div_hi, m_wrc;
   logic [15:0] m_div;
   logic [1:0]  m_flags;
   logic [7:0]  m_q[$];
   logic [7:0]  exp_q[$];
   logic        rdy_exp = 1'b0;

   rfg_regbank #(.FIFO_DEPTH(DEPTH), .ID_VALUE(8'hD5)) dut (
      .clk(clk), .res(res), .rfg_address(rfg_address), .rfg_read(rfg_read),
      .rfg_read_valid(rfg_read_valid), .rfg_read_value(rfg_read_value),
      .rfg_write(rfg_write), .rfg_write_last(rfg_write_last),
      .rfg_write_value(rfg_write_value), .cfg_ctrl(cfg_ctrl),
      .cfg_divider(cfg_divider), .status_in(status_in),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ctrl = 0; m_div_lo = 0; m_div_hi = 0; m_wrc = 0; m_div = 0; m_flags = 0;
      m_q.delete();
      exp_q.delete();
   endtask

   function automatic logic [7:0] model_read(input logic [15:0] a);
      case (a)
         16'h0000: return 8'hD5;
         16'h0001: return m_ctrl;
         16'h0002: return m_div_lo;
         16'h0003: return m_div_hi;
         16'h0004: return status_in;
         16'h0005: return 8'(m_q.size());
         16'h0006: return (m_q.size() > 0) ? m_q[0] : 8'h00;
         16'h0007: return {6'b0, m_flags};
         16'h0008: return m_wrc;
         default:  return 8'h00;
      endcase
   endfunction

   // Applies one clock edge worth of bus activity to the model, using pre-edge state.
   task automatic model_step(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [7:0] d, input logic last,
                             input logic psh, input logic [7:0] pd);
      int sz = m_q.size();
      logic [1:0] set = 2'b00;
      if (rd) exp_q.push_back(model_read(a));
      if (rd && a == 16'h0006) begin
         if (sz > 0) void'(m_q.pop_front());
         else set[0] = 1'b1;
      end
      if (psh && rdy_exp && sz < DEPTH) m_q.push_back(pd);
      if (wr) begin
         m_wrc = m_wrc + 8'd1;
         if (last) set[1] = 1'b1;
         case (a)
            16'h0001: m_ctrl = d;
            16'h0002: m_div_lo = d;
            16'h0003: begin m_div_hi = d; m_div = {d, m_div_lo}; end
            16'h0007: m_flags = m_flags & ~d[1:0];
            default: ;
         endcase
      end
      m_flags = m_flags | set;
   endtask

   task automatic op(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [7:0] d, input logic last,
                     input logic psh, input logic [7:0] pd);
      rfg_read = rd; rfg_write = wr; rfg_address = a; rfg_write_value = d;
      rfg_write_last = last; s_axis_tvalid = psh; s_axis_tdata = pd;
      @(posedge clk);
      model_step(rd, wr, a, d, last, psh, pd);
      #1;
      rfg_read = 0; rfg_write = 0; rfg_write_last = 0; s_axis_tvalid = 0;
   endtask

   task automatic rd(input logic [15:0] a);
      op(1, 0, a, 8'h00, 0, 0, 8'h00);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      op(0, 1, a, d, 0, 0, 8'h00);
   endtask

   task automatic push(input logic [7:0] d);
      op(0, 0, 16'h0000, 8'h00, 0, 1, d);
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rfg_read = 0;
      res = 0;
      #1 chk("tready_before_first_edge", s_axis_tready, 0);
      @(posedge clk);
      rdy_exp = 1;
      #1 chk("tready_after_first_edge", s_axis_tready, 1);
   endtask

   // Monitor: pops expected read data whenever the DUT presents a response.
   always @(negedge clk) begin
      if (!res) begin
         if (rfg_read_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_read_valid: got value 0x%0h, expected no response", rfg_read_value);
            end else begin
               chk("read_value", rfg_read_value, exp_q.pop_front());
            end
         end
         chk("s_axis_tready", s_axis_tready, rdy_exp && (m_q.size() < DEPTH));
         chk("cfg_ctrl", cfg_ctrl, m_ctrl);
         chk("cfg_divider", cfg_divider, m_div);
      end
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_tready", s_axis_tready, 0);
      chk("reset_read_valid", rfg_read_valid, 0);
      chk("reset_read_value", rfg_read_value, 0);
      chk("reset_ctrl", cfg_ctrl, 0);
      chk("reset_divider", cfg_divider, 0);
      release_reset();

      wr(16'h0001, 8'h5A);
      chk("ctrl_5a", cfg_ctrl, 8'h5A);
      rd(16'h0001);
      #4 chk("ctrl_read_valid", rfg_read_valid, 1);
      chk("ctrl_read_value", rfg_read_value, 8'h5A);

      wr(16'h0002, 8'h34);
      chk("div_after_lo", cfg_divider, 16'h0000);
      wr(16'h0003, 8'h12);
      chk("div_after_hi", cfg_divider, 16'h1234);

      status_in = 8'(($urandom & 32'hFF));
      rd(16'h0000); rd(16'h0004); rd(16'h0002); rd(16'h0003); rd(16'h1234);
      wr(16'h0000, 8'hFF); wr(16'h0004, 8'hFF); rd(16'h0000);

      for (int i = 1; i <= 8; i++) push(8'(i));
      chk("full_tready", s_axis_tready, 0);
      push(8'h99);
      rd(16'h0005);
      for (int i = 0; i < 9; i++) rd(16'h0006);
      rd(16'h0007);
      wr(16'h0007, 8'h01);
      rd(16'h0007);

      for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
      op(1, 0, 16'h0006, 8'h00, 0, 1, 8'hB0);
      rd(16'h0005);

      op(1, 1, 16'h0001, 8'hC3, 0, 0, 8'h00);
      rd(16'h0001);
      op(0, 1, 16'h0007, 8'h03, 1, 0, 8'h00);
      rd(16'h0007);
      op(1, 1, 16'h0006, 8'h01, 0, 0, 8'h00);
      rd(16'h0007);

      for (int i = 0; i < 400; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 15) == 0) ? 16'h00FF : 16'($urandom_range(0, 9));
         status_in = 8'(($urandom & 32'hFF));
         op(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), a,
            8'(($urandom & 32'hFF)), ($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 1)), 8'(($urandom & 32'hFF)));
      end

      while (m_q.size() < 3) push(8'(($urandom & 32'hFF)));
      @(negedge clk);
      rfg_address = 16'h0006;
      rfg_read = 1;
      res = 1;
      rdy_exp = 0;
      model_reset();
      #1;
      chk("rst_read_valid", rfg_read_valid, 0);
      chk("rst_tready", s_axis_tready, 0);
      chk("rst_divider", cfg_divider, 0);
      chk("rst_read_value", rfg_read_value, 0);
      release_reset();
      rd(16'h0005);
      rd(16'h0007);

      wr(16'h0001, 8'h3C); wr(16'h0002, 8'h11); wr(16'h0003, 8'h22);
      for (int i = 0; i < 253; i++) op(0, 1, 16'h00FF, 8'(($urandom & 32'hFF)), 0, 0, 8'h00);
      rd(16'h0008);
      rd(16'h0001); rd(16'h0002); rd(16'h0003);
      chk("wr_count_model_wrapped", {24'h0, m_wrc}, 0);

      repeat (4) @(posedge clk);
      #1 chk("pending_responses", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end of stimulus, expected completion within 200us");
      $fatal(1);
   end
endmodule

// File: doc/rfg_regbank.md
RFG_REGBANK -- requirements
Module: rfg_regbank

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, is the readout FIFO depth in bytes (power of two, 2..16).
REQ-002 Parameter ID_VALUE, default 8'hD5, is the constant returned by the ID register.
REQ-003 clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 res  in  1  reset, asynchronous and active-high.
REQ-005 rfg_address  in  16  register address, qualified by rfg_read or rfg_write.
REQ-006 rfg_read  in  1  one-cycle read strobe.
REQ-007 rfg_read_valid  out  1  one-cycle pulse marking rfg_read_value valid.
REQ-008 rfg_read_value  out  8  read data.
REQ-009 rfg_write  in  1  one-cycle write strobe.
REQ-010 rfg_write_last  in  1  marks the final byte of a write burst, qualified by rfg_write.
REQ-011 rfg_write_value  in  8  write data.
REQ-012 cfg_ctrl  out  8  CTRL register contents.
REQ-013 cfg_divider  out  16  committed divider value.
REQ-014 status_in  in  8  application status, sampled on read.
REQ-015 s_axis_tdata / s_axis_tvalid / s_axis_tready  in 8 / in 1 / out 1  readout FIFO push port.

Function
REQ-016 Register map:
- 0x0000 ID: RO, returns ID_VALUE.
- 0x0001 CTRL: RW.
- 0x0002 DIV_LO: RW shadow.
- 0x0003 DIV_HI: RW shadow.
- 0x0004 STATUS: RO, returns status_in.
- 0x0005 FIFO_COUNT: RO.
- 0x0006 FIFO_DATA: RO, pops the FIFO.
- 0x0007 FLAGS: bit0 underflow, bit1 burst_seen; write-1-to-clear.
- 0x0008 WR_COUNT: RO.
REQ-017 Read latency is exactly one cycle: rfg_read at edge N produces rfg_read_valid=1 and the value for exactly the cycle after N. rfg_read_value holds its last value otherwise.
REQ-018 Reads of unmapped addresses return 0x00 with rfg_read_valid; writes to unmapped or RO addresses are ignored.
REQ-019 A DIV_HI write updates the DIV_HI shadow and, in the same edge, sets cfg_divider to {new DIV_HI, DIV_LO shadow}. A DIV_LO write alone leaves cfg_divider unchanged.
REQ-020 WR_COUNT increments on every rfg_write, including writes to unmapped addresses, and wraps 0xFF->0x00.
REQ-021 FLAGS.bit1 sets on any rfg_write with rfg_write_last=1.
REQ-022 The FIFO accepts a byte when s_axis_tvalid && s_axis_tready; s_axis_tready=0 exactly when count==FIFO_DEPTH.
REQ-023 FIFO_DATA read when count>0 returns the head byte and pops it on the read edge.
REQ-024 FIFO_DATA read when empty returns 0x00, does not pop, and sets FLAGS.bit0.
REQ-025 Push and pop in the same edge leave count unchanged. Data ordering is strict FIFO, and pointers wrap modulo FIFO_DEPTH.
REQ-026 FIFO_COUNT reports the count before any same-edge push or pop, zero-extended to 8 bits.
REQ-027 Simultaneous rfg_read and rfg_write to the same address: the write takes effect and the read returns the pre-write value.
REQ-028 W1C to FLAGS in the same edge as a new set event leaves the flag set (set wins).

Reset
REQ-029 res asserted clears all of the following immediately, independent of clk:
- CTRL, DIV shadows, cfg_divider, WR_COUNT, FLAGS, FIFO pointers and count: 0.
- rfg_read_valid=0, rfg_read_value=0x00.
- s_axis_tready=0 while res=1.
REQ-030 Reset mid-operation discards FIFO contents and any pending read response; no rfg_read_valid is issued for a read strobed in the edge res asserts.
REQ-031 s_axis_tready goes to 1 on the first edge after res deasserts.

Structure
REQ-032 Package rfg_regbank_pkg holds the register address localparams (ADDR_ID..ADDR_WR_COUNT) and the FLAGS bit indices.
REQ-033 The FIFO is sub-module rfg_regbank_fifo (push/pop/count/full/empty, async active-high reset); all other logic stays in rfg_regbank.

Verification
REQ-034 Write 0x5A to 0x0001, then read 0x0001 -> cfg_ctrl=0x5A and rfg_read_valid one cycle after the strobe, with value 0x5A.
REQ-035 Write 0x34 to 0x0002, then 0x12 to 0x0003 -> cfg_divider stays 0x0000 after the first write and is 0x1234 after the second.
REQ-036 Push 8 bytes 0x01..0x08 -> s_axis_tready=0 and FIFO_COUNT reads 8; 8 FIFO_DATA reads return 0x01..0x08; a 9th read returns 0x00 and FLAGS reads 0x01.
REQ-037 With FIFO count 3, push and FIFO_DATA read in the same edge -> count remains 3 and the oldest byte is returned.
REQ-038 256 writes to 0x00FF -> WR_COUNT reads 0x00, and no register is changed.
REQ-039 Assert res during a read strobe with FIFO non-empty -> no rfg_read_valid, FIFO_COUNT reads 0, cfg_divider=0x0000.
